// File: rtl/alsu_pkg.sv
// Shared opcodes, widths and helpers for the alsu board-level arithmetic/logic/shift unit.
package alsu_pkg;

    localparam int IN_W  = 3;
    localparam int OUT_W = 6;
    localparam int LED_W = 16;

    localparam logic [2:0] OP_AND    = 3'b000;
    localparam logic [2:0] OP_XOR    = 3'b001;
    localparam logic [2:0] OP_ADD    = 3'b010;
    localparam logic [2:0] OP_MUL    = 3'b011;
    localparam logic [2:0] OP_SHIFT  = 3'b100;
    localparam logic [2:0] OP_ROTATE = 3'b101;

    function automatic logic [OUT_W-1:0] zext(input logic [IN_W-1:0] v);
        return {{(OUT_W-IN_W){1'b0}}, v};
    endfunction

    function automatic logic [OUT_W-1:0] zext1(input logic v);
        return {{(OUT_W-1){1'b0}}, v};
    endfunction

endpackage

// File: rtl/alsu_datapath.sv
// Combinational core of alsu: computes the next registered result and the invalid
// condition from the stage-1 registers and the current out value.
module alsu_datapath
    import alsu_pkg::*;
#(
    parameter bit PRIO_A  = 1'b1,
    parameter bit USE_CIN = 1'b1
) (
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    input  logic             cin,
    input  logic             serial_in,
    input  logic             red_op_a,
    input  logic             red_op_b,
    input  logic [2:0]       opcode,
    input  logic             bypass_a,
    input  logic             bypass_b,
    input  logic             direction,
    input  logic [OUT_W-1:0] cur_out,
    output logic [OUT_W-1:0] next_out,
    output logic             invalid
);

    logic red_any;
    logic red_use_a;

    assign red_any   = red_op_a | red_op_b;
    // With both reduction flags set the priority operand wins.
    assign red_use_a = (red_op_a & red_op_b) ? PRIO_A : red_op_a;
    assign invalid   = (opcode[2:1] == 2'b11) || (red_any && (opcode[2:1] != 2'b00));

    always_comb begin
        // NOTE: next_out gets a default before any branch so no path can infer a latch.
        next_out = '0;
        if (bypass_a && bypass_b) begin
            next_out = PRIO_A ? zext(a) : zext(b);
        end else if (bypass_a) begin
            next_out = zext(a);
        end else if (bypass_b) begin
            next_out = zext(b);
        end else if (!invalid) begin
            unique case (opcode)
                OP_AND: begin
                    if (red_any) next_out = red_use_a ? zext1(&a) : zext1(&b);
                    else         next_out = zext(a & b);
                end
                OP_XOR: begin
                    if (red_any) next_out = red_use_a ? zext1(^a) : zext1(^b);
                    else         next_out = zext(a ^ b);
                end
                OP_ADD:    next_out = zext(a) + zext(b) + zext1(cin & USE_CIN);
                OP_MUL:    next_out = zext(a) * zext(b);
                OP_SHIFT:  next_out = direction ? {cur_out[OUT_W-2:0], serial_in}
                                                : {serial_in, cur_out[OUT_W-1:1]};
                OP_ROTATE: next_out = direction ? {cur_out[OUT_W-2:0], cur_out[OUT_W-1]}
                                                : {cur_out[0], cur_out[OUT_W-1:1]};
                default:   next_out = '0;
            endcase
        end
    end

endmodule

// File: rtl/alsu.sv
// alsu top: stage-1 input registers, stage-2 result/LED registers around alsu_datapath.
// Optional port `invalid` is added when ALSU_INVALID_FLAG_EN is defined.
module alsu
    import alsu_pkg::*;
#(
    parameter INPUT_PRIORITY = "A",
    parameter FULL_ADDER     = "ON"
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  A,
    input  logic [IN_W-1:0]  B,
    input  logic             cin,
    input  logic             serial_in,
    input  logic             red_op_A,
    input  logic             red_op_B,
    input  logic [2:0]       opcode,
    input  logic             bypass_A,
    input  logic             bypass_B,
    input  logic             direction,
    output logic [LED_W-1:0] leds,
    output logic [OUT_W-1:0] out
`ifdef ALSU_INVALID_FLAG_EN
    ,
    output logic             invalid
`endif
);

    localparam bit PRIO_A  = (INPUT_PRIORITY == "A");
    localparam bit USE_CIN = (FULL_ADDER == "ON") || (FULL_ADDER == "on");

    logic [IN_W-1:0]  a_q, b_q;
    logic             cin_q, serial_in_q, red_op_a_q, red_op_b_q;
    logic             bypass_a_q, bypass_b_q, direction_q;
    logic [2:0]       opcode_q;
    logic [OUT_W-1:0] next_out;
    logic             invalid_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            serial_in_q <= 1'b0;
            red_op_a_q  <= 1'b0;
            red_op_b_q  <= 1'b0;
            opcode_q    <= '0;
            bypass_a_q  <= 1'b0;
            bypass_b_q  <= 1'b0;
            direction_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            a_q         <= A;
            b_q         <= B;
            cin_q       <= cin;
            serial_in_q <= serial_in;
            red_op_a_q  <= red_op_A;
            red_op_b_q  <= red_op_B;
            opcode_q    <= opcode;
            bypass_a_q  <= bypass_A;
            bypass_b_q  <= bypass_B;
            direction_q <= direction;
        end
    end

    alsu_datapath #(
        .PRIO_A  (PRIO_A),
        .USE_CIN (USE_CIN)
    ) u_datapath (
        .a         (a_q),
        .b         (b_q),
        .cin       (cin_q),
        .serial_in (serial_in_q),
        .red_op_a  (red_op_a_q),
        .red_op_b  (red_op_b_q),
        .opcode    (opcode_q),
        .bypass_a  (bypass_a_q),
        .bypass_b  (bypass_b_q),
        .direction (direction_q),
        .cur_out   (out),
        .next_out  (next_out),
        .invalid   (invalid_c)
    );

    // The LED bank blinks by inverting itself each cycle the request stays invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out  <= '0;
            leds <= '0;
        end else begin
            out  <= next_out;
            leds <= invalid_c ? ~leds : '0;
        end
    end

`ifdef ALSU_INVALID_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) invalid <= 1'b0;
        else     invalid <= invalid_c;
    end
`endif

endmodule

// File: tb/tb_alsu.sv
// Directed self-checking bench for alsu with INPUT_PRIORITY="A", FULL_ADDER="on".
module tb_alsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  A, B;
    logic        cin, serial_in, red_op_A, red_op_B;
    logic [2:0]  opcode;
    logic        bypass_A, bypass_B, direction;
    logic [15:0] leds;
    logic [5:0]  out;
`ifdef ALSU_INVALID_FLAG_EN
    logic        invalid;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;

    alsu #(
        .INPUT_PRIORITY ("A"),
        .FULL_ADDER     ("on")
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .cin       (cin),
        .serial_in (serial_in),
        .red_op_A  (red_op_A),
        .red_op_B  (red_op_B),
        .opcode    (opcode),
        .bypass_A  (bypass_A),
        .bypass_B  (bypass_B),
        .direction (direction),
        .leds      (leds),
        .out       (out)
`ifdef ALSU_INVALID_FLAG_EN
        ,
        .invalid   (invalid)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    endtask

    initial begin
        rst = 1'b1;
        A = 3'd0; B = 3'd0; cin = 1'b0; serial_in = 1'b0;
        red_op_A = 1'b0; red_op_B = 1'b0; opcode = 3'b000;
        bypass_A = 1'b0; bypass_B = 1'b0; direction = 1'b0;
        #12;
        check("reset_out",  {10'd0, out}, 16'd0);
        check("reset_leds", leds, 16'h0000);

        A = 3'd2; B = 3'd3; bypass_A = 1'b1;
        rst = 1'b0;
        tick(2); check("bypass_a", {10'd0, out}, 16'd2);
        bypass_A = 1'b0; bypass_B = 1'b1;
        tick(2); check("bypass_b", {10'd0, out}, 16'd3);
        bypass_A = 1'b1;
        tick(2); check("bypass_both_prio", {10'd0, out}, 16'd2);
        bypass_A = 1'b0; bypass_B = 1'b0;

        red_op_A = 1'b1; red_op_B = 1'b1; opcode = 3'b000;
        tick(2); check("red_and_both_a2", {10'd0, out}, 16'd0);
        opcode = 3'b001;
        tick(2); check("red_xor_both_a2", {10'd0, out}, 16'd1);
        A = 3'd7; opcode = 3'b000;
        tick(2); check("red_and_both_a7", {10'd0, out}, 16'd1);
        red_op_A = 1'b0; opcode = 3'b001;
        tick(2); check("red_xor_b_only", {10'd0, out}, 16'd0);
        red_op_A = 1'b1; red_op_B = 1'b0;
        tick(2); check("red_xor_a_only", {10'd0, out}, 16'd1);
        red_op_A = 1'b0;

        A = 3'd2; B = 3'd3; opcode = 3'b000;
        tick(2); check("and", {10'd0, out}, 16'd2);
        opcode = 3'b001;
        tick(2); check("xor", {10'd0, out}, 16'd1);
        opcode = 3'b010; cin = 1'b1;
        tick(2); check("add_cin1", {10'd0, out}, 16'd6);
        cin = 1'b0;
        tick(2); check("add_cin0", {10'd0, out}, 16'd5);
        A = 3'd7; B = 3'd7; cin = 1'b1;
        tick(2); check("add_max", {10'd0, out}, 16'd15);
        opcode = 3'b011;
        tick(2); check("mul_max", {10'd0, out}, 16'd49);
        A = 3'd2; B = 3'd3;
        tick(2); check("mul", {10'd0, out}, 16'd6);

        opcode = 3'b100; direction = 1'b1; serial_in = 1'b1;
        tick(2); check("shift_left_1", {10'd0, out}, 16'd13);
        tick(1); check("shift_left_2", {10'd0, out}, 16'd27);
        opcode = 3'b011;
        tick(2); check("mul_reload_1", {10'd0, out}, 16'd6);
        opcode = 3'b101; direction = 1'b0;
        tick(2); check("rotate_right", {10'd0, out}, 16'd3);
        opcode = 3'b011;
        tick(2); check("mul_reload_2", {10'd0, out}, 16'd6);
        opcode = 3'b101; direction = 1'b1;
        tick(2); check("rotate_left", {10'd0, out}, 16'd12);
        opcode = 3'b011;
        tick(2); check("mul_reload_3", {10'd0, out}, 16'd6);
        opcode = 3'b100; direction = 1'b0; serial_in = 1'b1;
        tick(2); check("shift_right", {10'd0, out}, 16'd35);

        opcode = 3'b110;
        tick(2); check("inv110_out", {10'd0, out}, 16'd0);
        check("inv110_leds_1", leds, 16'hFFFF);
`ifdef ALSU_INVALID_FLAG_EN
        check("inv110_flag", {15'd0, invalid}, 16'd1);
`endif
        tick(1); check("inv110_leds_2", leds, 16'h0000);
        tick(1); check("inv110_leds_3", leds, 16'hFFFF);
        opcode = 3'b010; red_op_A = 1'b1;
        tick(2); check("inv_red_out", {10'd0, out}, 16'd0);
        check("inv_red_leds", leds, 16'hFFFF);
        opcode = 3'b000; red_op_A = 1'b0;
        tick(2); check("valid_again_out", {10'd0, out}, 16'd2);
        check("valid_again_leds", leds, 16'h0000);
`ifdef ALSU_INVALID_FLAG_EN
        check("valid_again_flag", {15'd0, invalid}, 16'd0);
`endif

        opcode = 3'b111; bypass_A = 1'b1; A = 3'd5;
        tick(2); check("inv_bypass_out", {10'd0, out}, 16'd5);
        check("inv_bypass_leds_1", leds, 16'hFFFF);
        tick(1); check("inv_bypass_leds_2", leds, 16'h0000);
        tick(1); check("inv_bypass_leds_3", leds, 16'hFFFF);

        opcode = 3'b000;
        rst = 1'b1;
        #1;
        check("mid_rst_out", {10'd0, out}, 16'd0);
        check("mid_rst_leds", leds, 16'h0000);
        rst = 1'b0;
        tick(1); check("post_rst_edge1", {10'd0, out}, 16'd0);
        tick(1); check("post_rst_edge2", {10'd0, out}, 16'd5);
        check("post_rst_leds", leds, 16'h0000);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
